// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, refill state encoding and address field helpers
//
// Word address layout: {tag, index, offset}, offset being the word within a line.

package cache_pkg;

    localparam int ADDR_W         = 15;
    localparam int DATA_W         = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int INDEX_W        = 7;
    localparam int OFF_W          = $clog2(WORDS_PER_LINE);
    localparam int TAG_W          = ADDR_W - INDEX_W - OFF_W;

    typedef enum logic [1:0] {
        RS_IDLE = 2'd0,
        RS_REQ  = 2'd1,
        RS_RECV = 2'd2,
        RS_DONE = 2'd3
    } refill_state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W +: INDEX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W-1:0];
    endfunction

endpackage

// File: rtl/refill_beat_ctr.sv
// rtl/refill_beat_ctr.sv - beat counter, wrapped line offset, last-beat and requested-word detect
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   clear            zero the beat counter (burst granted)
//   advance          one beat accepted this cycle
//   start_off        offset of the first beat in the burst
//   req_off          offset of the word the requester asked for
//   offset           line offset of the current beat
//   last             current beat is the final beat of the line
//   match            current beat carries the requested word

module refill_beat_ctr
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [OFF_W-1:0] start_off,
    input  logic [OFF_W-1:0] req_off,
    output logic [OFF_W-1:0] offset,
    output logic             last,
    output logic             match
);

    logic [OFF_W-1:0] beat_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
        end else if (advance) begin
            beat_cnt <= beat_cnt + OFF_W'(1);
        end
    end

    // OFF_W-bit addition wraps modulo the line length on its own.
    assign offset = start_off + beat_cnt;
    assign last   = (beat_cnt == OFF_W'(WORDS_PER_LINE - 1));
    assign match  = (offset == req_off);

endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - cache miss refill engine: burst fetch, fill writes, word forward
//
// Optional feature macro: REFILL_CRITICAL_WORD_FIRST_EN
//   defined   - burst starts at the missing word and wraps around the line
//   undefined - burst starts at the line base, linear order
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   miss_valid/ready/addr     miss request from the datapath
//   mem_req/addr/gnt          burst read request to memory
//   mem_rvalid/rdata          read beats from memory
//   fill_we/index/offset/data/tag, fill_valid_set   writes into the data/tag arrays
//   fwd_valid/data            requested word back to the requester
//   busy                      refill in progress

module cache_refill_ctrl
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               miss_valid,
    output logic               miss_ready,
    input  logic [ADDR_W-1:0]  miss_addr,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               fill_we,
    output logic [INDEX_W-1:0] fill_index,
    output logic [OFF_W-1:0]   fill_offset,
    output logic [DATA_W-1:0]  fill_data,
    output logic [TAG_W-1:0]   fill_tag,
    output logic               fill_valid_set,
    output logic               fwd_valid,
    output logic [DATA_W-1:0]  fwd_data,
    output logic               busy
);

    localparam logic [1:0] S_IDLE = RS_IDLE;
    localparam logic [1:0] S_REQ  = RS_REQ;
    localparam logic [1:0] S_RECV = RS_RECV;
    localparam logic [1:0] S_DONE = RS_DONE;

    logic [1:0]        state;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [OFF_W-1:0]  start_off;
    logic [OFF_W-1:0]  cur_off;
    logic              beat;
    logic              last_beat;
    logic              req_match;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    assign mem_addr_next = miss_addr;
    assign start_off     = addr_offset(req_addr);
`else
    assign mem_addr_next = {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign start_off     = '0;
`endif

    assign beat       = (state == S_RECV) && mem_rvalid;
    assign miss_ready = (state == S_IDLE);
    assign mem_req    = (state == S_REQ);
    assign busy       = (state != S_IDLE);

    refill_beat_ctr u_beat_ctr (
        .clk       (clk),
        .rst       (rst),
        .clear     ((state == S_REQ) && mem_gnt),
        .advance   (beat),
        .start_off (start_off),
        .req_off   (addr_offset(req_addr)),
        .offset    (cur_off),
        .last      (last_beat),
        .match     (req_match)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            req_addr <= '0;
            mem_addr <= '0;
        end else begin
            case (state)
                S_IDLE: if (miss_valid) begin
                    state    <= S_REQ;
                    req_addr <= miss_addr;
                    mem_addr <= mem_addr_next;
                end
                S_REQ:   if (mem_gnt) state <= S_RECV;
                S_RECV:  if (mem_rvalid && last_beat) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Fill path is one register stage behind the beat; the last fill lands in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_we        <= 1'b0;
            fill_valid_set <= 1'b0;
            fwd_valid      <= 1'b0;
            fill_index     <= '0;
            fill_offset    <= '0;
            fill_data      <= '0;
            fill_tag       <= '0;
            fwd_data       <= '0;
        end else begin
            fill_we        <= beat;
            fill_valid_set <= beat && last_beat;
            fwd_valid      <= beat && req_match;
            if (beat) begin
                fill_index  <= addr_index(req_addr);
                fill_offset <= cur_off;
                fill_data   <= mem_rdata;
                fill_tag    <= addr_tag(req_addr);
            end
            if (beat && req_match) begin
                fwd_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - self-checking bench for cache_refill_ctrl

module tb_cache_refill_ctrl;
    import cache_pkg::*;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               miss_valid = 1'b0;
    logic               miss_ready;
    logic [ADDR_W-1:0]  miss_addr = '0;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_gnt = 1'b0;
    logic               mem_rvalid = 1'b0;
    logic [DATA_W-1:0]  mem_rdata = '0;
    logic               fill_we;
    logic [INDEX_W-1:0] fill_index;
    logic [OFF_W-1:0]   fill_offset;
    logic [DATA_W-1:0]  fill_data;
    logic [TAG_W-1:0]   fill_tag;
    logic               fill_valid_set;
    logic               fwd_valid;
    logic [DATA_W-1:0]  fwd_data;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_refill_ctrl dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fill_we(fill_we), .fill_index(fill_index), .fill_offset(fill_offset),
        .fill_data(fill_data), .fill_tag(fill_tag), .fill_valid_set(fill_valid_set),
        .fwd_valid(fwd_valid), .fwd_data(fwd_data), .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string t);
        check_eq({t, "_miss_ready"}, 32'(miss_ready), 1);
        check_eq({t, "_mem_req"}, 32'(mem_req), 0);
        check_eq({t, "_mem_addr"}, 32'(mem_addr), 0);
        check_eq({t, "_fill_we"}, 32'(fill_we), 0);
        check_eq({t, "_fill_valid_set"}, 32'(fill_valid_set), 0);
        check_eq({t, "_fwd_valid"}, 32'(fwd_valid), 0);
        check_eq({t, "_busy"}, 32'(busy), 0);
        check_eq({t, "_fill_fields"}, 32'({fill_index, fill_offset, fill_tag}), 0);
        check_eq({t, "_fill_data"}, fill_data, 0);
        check_eq({t, "_fwd_data"}, fwd_data, 0);
    endtask

    // One full miss. gaps holds four 4-bit idle-cycle counts, one before each beat.
    task automatic refill(input logic [ADDR_W-1:0] a, input int gnt_wait, input logic [15:0] gaps,
                          input bit rand_data, input bit stray, input bit hold_miss);
        int ai, req, start, exp_base, exp_tag, exp_idx, off, ng;
        logic [31:0] d;
        ai       = int'(a);
        req      = ai % WORDS_PER_LINE;
        exp_base = CWF ? ai : ai - req;
        start    = CWF ? req : 0;
        exp_idx  = (ai / WORDS_PER_LINE) % (1 << INDEX_W);
        exp_tag  = ai / (WORDS_PER_LINE * (1 << INDEX_W));

        if (stray) begin
            mem_rvalid = 1'b1;
            mem_gnt    = 1'b1;
            tick();
            mem_rvalid = 1'b0;
            mem_gnt    = 1'b0;
            check_eq("stray_idle_fill_we", 32'(fill_we), 0);
            check_eq("stray_idle_mem_req", 32'(mem_req), 0);
        end
        check_eq("idle_ready", 32'(miss_ready), 1);

        miss_valid = 1'b1;
        miss_addr  = a;
        tick();
        if (hold_miss) miss_addr = ~a;
        else           miss_valid = 1'b0;
        check_eq("req_mem_req", 32'(mem_req), 1);
        check_eq("req_mem_addr", 32'(mem_addr), exp_base);
        check_eq("req_ready", 32'(miss_ready), 0);
        check_eq("req_busy", 32'(busy), 1);

        for (int w = 0; w < gnt_wait; w++) begin
            mem_rvalid = stray;
            tick();
            check_eq("wait_mem_req", 32'(mem_req), 1);
            check_eq("wait_mem_addr", 32'(mem_addr), exp_base);
            check_eq("wait_fill_we", 32'(fill_we), 0);
        end
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check_eq("gnt_mem_req_drop", 32'(mem_req), 0);
        check_eq("gnt_fill_we", 32'(fill_we), 0);

        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            ng = int'(gaps[4*k +: 4]);
            for (int g = 0; g < ng; g++) begin
                mem_rvalid = 1'b0;
                mem_gnt    = stray;
                tick();
                check_eq("gap_fill_we", 32'(fill_we), 0);
                check_eq("gap_mem_req", 32'(mem_req), 0);
                check_eq("gap_ready", 32'(miss_ready), 0);
            end
            d          = rand_data ? $urandom : 32'hA0 + 32'(k);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = d;
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            off = (start + k) % WORDS_PER_LINE;
            check_eq("fill_we", 32'(fill_we), 1);
            check_eq("fill_offset", 32'(fill_offset), off);
            check_eq("fill_data", fill_data, d);
            check_eq("fill_tag", 32'(fill_tag), exp_tag);
            check_eq("fill_index", 32'(fill_index), exp_idx);
            check_eq("fill_valid_set", 32'(fill_valid_set), (k == WORDS_PER_LINE - 1) ? 1 : 0);
            check_eq("fwd_valid", 32'(fwd_valid), (off == req) ? 1 : 0);
            if (off == req) check_eq("fwd_data", fwd_data, d);
            check_eq("beat_mem_req", 32'(mem_req), 0);
            check_eq("beat_ready", 32'(miss_ready), 0);
        end

        tick();
        miss_valid = 1'b0;
        check_eq("end_ready", 32'(miss_ready), 1);
        check_eq("end_busy", 32'(busy), 0);
        check_eq("end_fill_we", 32'(fill_we), 0);
        check_eq("end_valid_set", 32'(fill_valid_set), 0);
        check_eq("end_mem_req", 32'(mem_req), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        check_reset_vals("reset");
        rst = 1'b1;
        tick();

        refill(15'h1236, 2, 16'h0000, 1'b0, 1'b0, 1'b0);
        refill(15'h2A5B, 1, 16'h3021, 1'b1, 1'b0, 1'b0);
        refill(15'h0F3D, 2, 16'h0010, 1'b1, 1'b1, 1'b1);

        // Reset in the middle of a burst, two of four beats delivered.
        miss_valid = 1'b1;
        miss_addr  = 15'h1236;
        tick();
        miss_valid = 1'b0;
        mem_gnt    = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            tick();
            check_eq("partial_fill_we", 32'(fill_we), 1);
            check_eq("partial_valid_set", 32'(fill_valid_set), 0);
        end
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("async_rst");
        tick();
        check_reset_vals("held_rst");
        mem_rvalid = 1'b0;
        rst = 1'b1;
        tick();
        check_eq("post_rst_fill_we", 32'(fill_we), 0);
        check_eq("post_rst_valid_set", 32'(fill_valid_set), 0);
        refill(15'h0004, 0, 16'h0000, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            refill(15'($urandom), int'($urandom_range(0, 3)), 16'($urandom) & 16'h3333,
                   1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
